sdram_arbiter: RTL and testbench

// Shares the single SDRAM controller port between the three bus masters: N64 bus, CPU bus and DMA engine.
// N64 has fixed top priority because cart reads are latency-critical.
// CPU and DMA share the remaining slots round-robin.
// A starvation counter forces a low-priority grant after STARVE_LIMIT consecutive N64 wins.

---
 rtl/sdram_arbiter_pkg.sv | 22 ++
 rtl/sdram_arbiter_select.sv | 38 +++
 rtl/sdram_arbiter.sv | 113 +++++++++++
 tb/tb_sdram_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared types and constants for the SDRAM port arbiter: master ids, FSM states
// and the default starvation limit.
package sdram_arbiter_pkg;

    typedef enum bit [1:0] {
        ID_SDRAM_N64,
        ID_SDRAM_CPU,
        ID_SDRAM_DMA,
        __ID_SDRAM_END
    } e_sdram_master;

    parameter int SDRAM_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } e_arb_state;

    localparam logic [1:0] GRANT_NONE = 2'd3;

endpackage

// File: rtl/sdram_arbiter_select.sv
// Combinational winner pick: starvation override, then fixed N64 priority,
// then CPU/DMA round-robin against the last low-priority owner.
module sdram_arbiter_select
    import sdram_arbiter_pkg::*;
(
    input  logic [2:0]    request,
    input  logic          starved,
    input  e_sdram_master rr_last,
    output logic          valid,
    output e_sdram_master id
);

    logic          low_pending;
    e_sdram_master low_id;

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        valid       = |request;
        id          = ID_SDRAM_N64;
        low_pending = request[ID_SDRAM_CPU] | request[ID_SDRAM_DMA];
        low_id      = ID_SDRAM_CPU;

        if (request[ID_SDRAM_CPU] && request[ID_SDRAM_DMA]) begin
            low_id = (rr_last == ID_SDRAM_CPU) ? ID_SDRAM_DMA : ID_SDRAM_CPU;
        end else if (request[ID_SDRAM_DMA]) begin
            low_id = ID_SDRAM_DMA;
        end

        if (starved && low_pending) begin
            id = low_id;
        end else if (request[ID_SDRAM_N64]) begin
            id = ID_SDRAM_N64;
        end else if (low_pending) begin
            id = low_id;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the single SDRAM controller port between N64, CPU and DMA masters:
// IDLE picks and latches a winner, ACCESS holds the request, DONE acks for one cycle.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = SDRAM_STARVE_LIMIT
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic [2:0]             req_request,
    input  logic [2:0]             req_write,
    input  logic [2:0][ADDR_W-1:0] req_address,
    input  logic [2:0][DATA_W-1:0] req_wdata,
    output logic [2:0]             req_ack,
    output logic [DATA_W-1:0]      req_rdata,

    output logic                   mem_request,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,

    output logic [1:0]             grant_id
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    e_arb_state    state, next_state;
    logic [CNT_W-1:0] starve_cnt;
    e_sdram_master rr_last;
    logic [1:0]    grant_q;
    logic          starved;
    logic          low_pending;
    logic          sel_valid;
    e_sdram_master sel_id;

    assign starved     = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign low_pending = req_request[ID_SDRAM_CPU] | req_request[ID_SDRAM_DMA];
    assign grant_id    = grant_q;

    sdram_arbiter_select u_select (
        .request (req_request),
        .starved (starved),
        .rr_last (rr_last),
        .valid   (sel_valid),
        .id      (sel_id)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // mem_request and req_ack decode straight from state, so reset drops them at once.
    always_comb begin
        next_state  = state;
        mem_request = 1'b0;
        req_ack     = 3'b000;
        case (state)
            ST_IDLE: begin
                if (sel_valid) next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_request = 1'b1;
                if (mem_ack) next_state = ST_DONE;
            end
            ST_DONE: begin
                req_ack    = 3'b001 << grant_q;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q     <= GRANT_NONE;
            starve_cnt  <= '0;
            rr_last     <= ID_SDRAM_DMA;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            req_rdata   <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (!low_pending) starve_cnt <= '0;
                if (sel_valid) begin
                    grant_q     <= sel_id;
                    mem_write   <= req_write[sel_id];
                    mem_address <= req_address[sel_id];
                    mem_wdata   <= req_wdata[sel_id];
                    if (sel_id == ID_SDRAM_N64) begin
                        if (low_pending && !starved) starve_cnt <= starve_cnt + 1'b1;
                    end else begin
                        starve_cnt <= '0;
                        rr_last    <= sel_id;
                    end
                end
            end
            // Ack outside ACCESS is a stray pulse and must not disturb read data.
            if (state == ST_ACCESS && mem_ack) req_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter: latency, priority/starvation,
// round-robin, operand stability, async reset and stray mem_ack.
module tb_sdram_arbiter;

    logic              clk;
    logic              reset_n;
    logic [2:0]        req_request;
    logic [2:0]        req_write;
    logic [2:0][25:0]  req_address;
    logic [2:0][15:0]  req_wdata;
    logic [2:0]        req_ack;
    logic [15:0]       req_rdata;
    logic              mem_request;
    logic              mem_write;
    logic [25:0]       mem_address;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic [1:0]        grant_id;

    int checks = 0;
    int errors = 0;

    sdram_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_request (req_request),
        .req_write   (req_write),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .req_ack     (req_ack),
        .req_rdata   (req_rdata),
        .mem_request (mem_request),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n     = 1'b0;
        req_request = '0;
        req_write   = '0;
        req_address = '0;
        req_wdata   = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    // Wait for mem_request, ack after 'delay' cycles, report the acked master,
    // then drop every request bit of the served master not listed in 'keep'.
    task automatic serve(input int delay, input logic [15:0] rdata, input logic [2:0] keep,
                         output int who);
        int n;
        n   = 0;
        who = -1;
        while (!mem_request && n < 20) begin
            step();
            n++;
        end
        if (!mem_request) begin
            check("mem_request_timeout", 0, 1);
            return;
        end
        repeat (delay) step();
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) if (req_ack[i]) who = i;
        if (who >= 0) check("serve_rdata", req_rdata, rdata);
        step();
        if (who >= 0 && !keep[who]) req_request[who] = 1'b0;
    endtask

    int who;
    int order2 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
    int order3 [4]  = '{1, 2, 1, 2};

    initial begin
        // Test 1: reset values and single CPU read latency.
        apply_reset();
        check("rst_mem_request", mem_request, 0);
        check("rst_req_ack", req_ack, 0);
        check("rst_req_rdata", req_rdata, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_grant_id", grant_id, 3);

        req_request[1] = 1'b1;
        req_address[1] = 26'h0000100;
        check("t1_c0_mem_request", mem_request, 0);
        step();
        check("t1_c1_mem_request", mem_request, 1);
        check("t1_c1_mem_address", mem_address, 26'h0000100);
        check("t1_c1_grant_id", grant_id, 1);
        step();
        check("t1_c2_req_ack", req_ack, 0);
        step();
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        check("t1_c4_req_ack", req_ack, 3'b010);
        check("t1_c4_req_rdata", req_rdata, 16'hBEEF);
        check("t1_c4_mem_request", mem_request, 0);
        step();
        req_request = '0;
        check("t1_c5_req_ack", req_ack, 0);

        // Test 2: all three requesting, N64 held; starvation override every 5th grant.
        apply_reset();
        req_request    = 3'b111;
        req_address[0] = 26'h10;
        req_address[1] = 26'h20;
        req_address[2] = 26'h30;
        for (int i = 0; i < 10; i++) begin
            serve(0, 16'(16'h0100 + i), 3'b001, who);
            check($sformatf("t2_grant_%0d", i), who, order2[i]);
        end
        req_request = '0;

        // Test 3: CPU and DMA continuous -> strict alternation, no starvation count.
        apply_reset();
        req_request = 3'b110;
        for (int i = 0; i < 4; i++) begin
            serve(1, 16'(16'h0200 + i), 3'b110, who);
            check($sformatf("t3_grant_%0d", i), who, order3[i]);
            check($sformatf("t3_starve_%0d", i), dut.starve_cnt, 0);
        end
        req_request = '0;

        // Test 4: DMA write stays stable while N64 arrives mid-access.
        apply_reset();
        req_request[2] = 1'b1;
        req_write[2]   = 1'b1;
        req_address[2] = 26'h3FFFFFE;
        req_wdata[2]   = 16'h1234;
        step();
        req_request[0] = 1'b1;
        req_address[0] = 26'h40;
        for (int i = 0; i < 3; i++) begin
            check("t4_mem_request", mem_request, 1);
            check("t4_mem_write", mem_write, 1);
            check("t4_mem_address", mem_address, 26'h3FFFFFE);
            check("t4_mem_wdata", mem_wdata, 16'h1234);
            check("t4_grant_dma", grant_id, 2);
            step();
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("t4_done_ack", req_ack, 3'b100);
        check("t4_done_grant", grant_id, 2);
        check("t4_done_mem_request", mem_request, 0);
        step();
        req_request[2] = 1'b0;
        check("t4_idle_mem_request", mem_request, 0);
        step();
        check("t4_n64_mem_request", mem_request, 1);
        check("t4_n64_grant", grant_id, 0);
        check("t4_n64_write", mem_write, 0);
        check("t4_n64_address", mem_address, 26'h40);
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        step();
        mem_ack = 1'b0;
        check("t4_n64_ack", req_ack, 3'b001);
        check("t4_n64_rdata", req_rdata, 16'h7777);
        step();
        req_request = '0;

        // Test 5: asynchronous reset during an N64 access.
        req_request[0] = 1'b1;
        req_write[0]   = 1'b0;
        req_address[0] = 26'h55;
        step();
        check("t5_pre_mem_request", mem_request, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_async_mem_request", mem_request, 0);
        check("t5_async_req_ack", req_ack, 0);
        check("t5_async_grant", grant_id, 3);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        check("t5_state_idle", dut.state, 0);
        serve(1, 16'h5A5A, 3'b000, who);
        check("t5_reissue_who", who, 0);

        // Test 6: stray mem_ack while idle is ignored.
        mem_ack   = 1'b1;
        mem_rdata = 16'hAAAA;
        step();
        mem_ack = 1'b0;
        check("t6_req_ack", req_ack, 0);
        check("t6_mem_request", mem_request, 0);
        check("t6_req_rdata", req_rdata, 16'h5A5A);
        check("t6_state", dut.state, 0);
        step();
        check("t6_req_ack_next", req_ack, 0);
        check("t6_state_next", dut.state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
